// File: rtl/mem_dump_reader_pkg.sv
// Shared definitions for the memory dump reader and the debug UART unit.
package mem_dump_reader_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    // state | meaning
    // IDLE  | waiting for a start request, debug address parked at 0
    // ADDR  | debug address presented, memory registers the word
    // LATCH | registered word captured into the serializer
    // SEND  | bytes of the current word streamed LSB first
    // DONE  | one-cycle completion pulse, address returns to 0
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_LATCH = 3'd2;
    localparam logic [2:0] ST_SEND  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        ADDR  = ST_ADDR,
        LATCH = ST_LATCH,
        SEND  = ST_SEND,
        DONE  = ST_DONE
    } dump_state_e;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

    localparam int BYTES_PER_WORD = bytes_per_word(DEFAULT_DATA_WIDTH);

endpackage

// File: rtl/mem_dump_reader_word_serializer.sv
// Loads one memory word and streams it out LSB byte first over valid/ready.
module mem_dump_reader_word_serializer
    import mem_dump_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] word_i,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic                  last_accept_o
);

    localparam int BPW   = bytes_per_word(DATA_WIDTH);
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  valid_q, valid_d;
    logic                  accept;

    assign accept        = valid_q && tx_ready_i;
    assign last_accept_o = accept && (idx_q == LAST_IDX);
    assign tx_data_o     = shreg_q[7:0];
    assign tx_valid_o    = valid_q;

    // Next-state: load a fresh word, or shift out one byte per accepted transfer.
    always_comb begin
        shreg_d = shreg_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        if (load_i) begin
            shreg_d = word_i;
            idx_d   = '0;
            valid_d = 1'b1;
        end else if (accept) begin
            shreg_d = shreg_q >> 8;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
                valid_d = 1'b0;
            end
        end
    end

    // Shift register, byte index and valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/mem_dump_reader.sv
// Walks the whole data memory through its debug port and streams it as bytes.
module mem_dump_reader
    import mem_dump_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 64,
    parameter int ADDR_WIDTH = $clog2(MEM_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    output logic [ADDR_WIDTH-1:0] o_debug_addr,
    input  logic [DATA_WIDTH-1:0] i_debug_data,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int BPW = bytes_per_word(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BPW);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - BPW);

    dump_state_e           state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  ser_load;
    logic                  ser_last;

    assign ser_load     = (state_q == LATCH);
    assign o_debug_addr = addr_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

    mem_dump_reader_word_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .clk           (clk),
        .rst           (rst),
        .load_i        (ser_load),
        .word_i        (i_debug_data),
        .tx_data_o     (o_tx_data),
        .tx_valid_o    (o_tx_valid),
        .tx_ready_i    (i_tx_ready),
        .last_accept_o (ser_last)
    );

    // Dump sequencer: address walk plus registered busy/done flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        state_q <= ADDR;
                        addr_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ADDR: begin
                    state_q <= LATCH;
                end
                LATCH: begin
                    state_q <= SEND;
                end
                SEND: begin
                    if (ser_last) begin
                        // Compare before adding so the counter never steps past the last word.
                        if (addr_q == LAST_ADDR) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q  <= addr_q + ADDR_STEP;
                            state_q <= ADDR;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    addr_q  <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    addr_q  <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed bench for mem_dump_reader: default 64-byte instance and a 16-byte instance.
module tb_mem_dump_reader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start, ready;
    logic [5:0]  addr;
    logic [31:0] dbg;
    logic [7:0]  txd;
    logic        txv, busy, done;

    logic        s_start, s_ready;
    logic [3:0]  s_addr;
    logic [31:0] s_dbg;
    logic [7:0]  s_txd;
    logic        s_txv, s_busy, s_done;

    logic [7:0] mem [0:63];

    int passed = 0;
    int total  = 0;

    logic [7:0] got_bytes [$];
    int         got_addr  [$];
    int done_cycle, done_count, stall_count, stab_err, first_valid;

    mem_dump_reader dut (
        .clk(clk), .rst(rst), .i_start(start), .o_debug_addr(addr), .i_debug_data(dbg),
        .o_tx_data(txd), .o_tx_valid(txv), .i_tx_ready(ready), .o_busy(busy), .o_done(done)
    );

    mem_dump_reader #(.DATA_WIDTH(32), .MEM_SIZE(16)) dut16 (
        .clk(clk), .rst(rst), .i_start(s_start), .o_debug_addr(s_addr), .i_debug_data(s_dbg),
        .o_tx_data(s_txd), .o_tx_valid(s_txv), .i_tx_ready(s_ready), .o_busy(s_busy), .o_done(s_done)
    );

    // Memory debug ports: word registered one cycle after the address.
    always @(posedge clk) begin
        dbg   <= {mem[int'(addr)+3], mem[int'(addr)+2], mem[int'(addr)+1], mem[int'(addr)]};
        s_dbg <= {mem[int'(s_addr)+3], mem[int'(s_addr)+2], mem[int'(s_addr)+1], mem[int'(s_addr)]};
    end

    task automatic run_dump(input int ready_mode, input bit restart);
        logic       prev_stall;
        logic [7:0] prev_data;
        int         cyc;
        got_bytes.delete();
        got_addr.delete();
        done_cycle = -1; done_count = 0; stall_count = 0; stab_err = 0; first_valid = -1;
        prev_stall = 1'b0; prev_data = 8'h00;
        @(posedge clk); #1;
        start = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        ready = (ready_mode == 0) ? 1'b1 : (cyc % 2 == 1);
        while (cyc < 600) begin
            @(negedge clk);
            if (prev_stall && (!txv || txd !== prev_data)) stab_err++;
            if (txv && first_valid < 0) first_valid = cyc;
            if (txv && ready) begin
                got_bytes.push_back(txd);
                got_addr.push_back(int'(addr));
            end
            if (txv && !ready) stall_count++;
            prev_stall = txv && !ready;
            prev_data  = txd;
            if (done) begin
                done_count++;
                if (done_cycle < 0) done_cycle = cyc;
            end
            if (done_cycle >= 0 && cyc >= done_cycle + 8) break;
            @(posedge clk); #1;
            cyc++;
            ready = (ready_mode == 0) ? 1'b1 : (cyc % 2 == 1);
            start = restart && (cyc == 10 || cyc == 50);
        end
        start = 1'b0;
        ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; ready = 1'b0; s_start = 1'b1; s_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (addr !== 6'd0) $display("FAIL reset_addr got %0d want 0", addr); else passed++;
        total++; if (txd !== 8'h00) $display("FAIL reset_tx_data got %0h want 0", txd); else passed++;
        total++; if (txv !== 1'b0) $display("FAIL reset_tx_valid got %b want 0", txv); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy_start_ignored got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        total++; if (s_busy !== 1'b0) $display("FAIL reset_busy16 got %b want 0", s_busy); else passed++;
        start = 1'b0; s_start = 1'b0; ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL idle_after_reset_busy got %b want 0", busy); else passed++;
    endtask

    task automatic test_full_dump;
        int errs, aerrs;
        run_dump(0, 1'b0);
        errs = 0; aerrs = 0;
        foreach (got_bytes[i]) if (got_bytes[i] !== 8'(i)) errs++;
        foreach (got_addr[i]) if (got_addr[i] !== (i / 4) * 4) aerrs++;
        total++; if (got_bytes.size() !== 64) $display("FAIL full_byte_count got %0d want 64", got_bytes.size()); else passed++;
        total++; if (errs !== 0) $display("FAIL full_stream got %0d wrong bytes want 0", errs); else passed++;
        total++; if (aerrs !== 0) $display("FAIL full_addr_steps got %0d wrong addrs want 0", aerrs); else passed++;
        total++; if (first_valid !== 3) $display("FAIL first_valid_cycle got %0d want 3", first_valid); else passed++;
        total++; if (done_cycle !== 97) $display("FAIL full_done_cycle got %0d want 97", done_cycle); else passed++;
        total++; if (done_count !== 1) $display("FAIL full_done_count got %0d want 1", done_count); else passed++;
        total++; if (busy !== 1'b0 || addr !== 6'd0) $display("FAIL full_idle_after busy=%b addr=%0d want 0/0", busy, addr); else passed++;
    endtask

    task automatic test_ready_toggle;
        int errs;
        run_dump(1, 1'b0);
        errs = 0;
        foreach (got_bytes[i]) if (got_bytes[i] !== 8'(i)) errs++;
        total++; if (got_bytes.size() !== 64) $display("FAIL toggle_byte_count got %0d want 64", got_bytes.size()); else passed++;
        total++; if (errs !== 0) $display("FAIL toggle_stream got %0d wrong bytes want 0", errs); else passed++;
        total++; if (stab_err !== 0) $display("FAIL toggle_data_stable got %0d violations want 0", stab_err); else passed++;
        total++; if (stall_count < 1) $display("FAIL toggle_stalls got %0d want >0", stall_count); else passed++;
        total++; if (done_cycle !== 97 + stall_count) $display("FAIL toggle_done_cycle got %0d want %0d", done_cycle, 97 + stall_count); else passed++;
    endtask

    task automatic test_deadbeef;
        mem[8] = 8'hEF; mem[9] = 8'hBE; mem[10] = 8'hAD; mem[11] = 8'hDE;
        run_dump(0, 1'b0);
        total++; if (got_bytes[8]  !== 8'hEF) $display("FAIL beef_byte8 got %h want ef", got_bytes[8]); else passed++;
        total++; if (got_bytes[9]  !== 8'hBE) $display("FAIL beef_byte9 got %h want be", got_bytes[9]); else passed++;
        total++; if (got_bytes[10] !== 8'hAD) $display("FAIL beef_byte10 got %h want ad", got_bytes[10]); else passed++;
        total++; if (got_bytes[11] !== 8'hDE) $display("FAIL beef_byte11 got %h want de", got_bytes[11]); else passed++;
        total++; if (got_bytes[12] !== 8'h0C) $display("FAIL beef_byte12 got %h want 0c", got_bytes[12]); else passed++;
        for (int i = 8; i < 12; i++) mem[i] = 8'(i);
    endtask

    task automatic test_restart_ignored;
        run_dump(0, 1'b1);
        total++; if (got_bytes.size() !== 64) $display("FAIL restart_byte_count got %0d want 64", got_bytes.size()); else passed++;
        total++; if (done_count !== 1) $display("FAIL restart_done_count got %0d want 1", done_count); else passed++;
        total++; if (done_cycle !== 97) $display("FAIL restart_done_cycle got %0d want 97", done_cycle); else passed++;
    endtask

    task automatic test_rst_mid_dump;
        bit found;
        int errs, dones;
        found = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (txv && addr == 6'd20) found = 1'b1;
        end
        total++; if (!found) $display("FAIL rst_reach_send20 got timeout want SEND at 20"); else passed++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (txv !== 1'b0) $display("FAIL rst_mid_valid got %b want 0", txv); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", busy); else passed++;
        total++; if (addr !== 6'd0) $display("FAIL rst_mid_addr got %0d want 0", addr); else passed++;
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            if (done) dones++;
            @(negedge clk);
        end
        total++; if (dones !== 0) $display("FAIL rst_mid_no_done got %0d pulses want 0", dones); else passed++;
        run_dump(0, 1'b0);
        errs = 0;
        foreach (got_bytes[i]) if (got_bytes[i] !== 8'(i)) errs++;
        total++; if (got_bytes.size() !== 64 || errs !== 0) $display("FAIL rst_redump got %0d bytes %0d wrong want 64/0", got_bytes.size(), errs); else passed++;
        total++; if (got_addr[0] !== 0) $display("FAIL rst_redump_first_addr got %0d want 0", got_addr[0]); else passed++;
    endtask

    task automatic test_small_mem;
        int cyc, nbytes, errs, max_addr, dcyc, dcount;
        nbytes = 0; errs = 0; max_addr = -1; dcyc = -1; dcount = 0;
        s_ready = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        cyc = 1;
        while (cyc < 200) begin
            @(negedge clk);
            if (s_busy && int'(s_addr) > max_addr) max_addr = int'(s_addr);
            if (s_txv && s_ready) begin
                if (s_txd !== 8'(nbytes)) errs++;
                nbytes++;
            end
            if (s_done) begin
                dcount++;
                if (dcyc < 0) dcyc = cyc;
            end
            if (dcyc >= 0 && cyc >= dcyc + 5) break;
            @(posedge clk); #1;
            cyc++;
        end
        total++; if (nbytes !== 16) $display("FAIL small_byte_count got %0d want 16", nbytes); else passed++;
        total++; if (errs !== 0) $display("FAIL small_stream got %0d wrong want 0", errs); else passed++;
        total++; if (max_addr !== 12) $display("FAIL small_last_addr got %0d want 12", max_addr); else passed++;
        total++; if (dcyc !== 25) $display("FAIL small_done_cycle got %0d want 25", dcyc); else passed++;
        total++; if (dcount !== 1) $display("FAIL small_done_count got %0d want 1", dcount); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);
        rst = 1'b1; start = 1'b0; ready = 1'b1; s_start = 1'b0; s_ready = 1'b1;
        test_reset();
        test_full_dump();
        test_ready_toggle();
        test_deadbeef();
        test_restart_ignored();
        test_rst_mid_dump();
        test_small_mem();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_dump_reader.md
# mem_dump_reader

Debug-side reader for the data memory's debug port. On a start pulse it walks the whole data memory word by word and drives the debug address. It captures each registered debug word and serializes it as a little-endian byte stream on a valid/ready interface toward the debug UART transmitter. It sits between the data memory debug port and the debug/UART unit and never touches the load/store path.

## Interface
- DATA_WIDTH, 32, memory word width; multiple of 8
- MEM_SIZE, 64, data memory size in bytes; multiple of DATA_WIDTH/8
- ADDR_WIDTH, $clog2(MEM_SIZE), byte-address width
- clk  input  1  clock; all logic on posedge
- rst  input  1  reset; one clock; reset is synchronous and active-high
- i_start  input  1  one-cycle request to dump the full memory
- o_debug_addr  output  ADDR_WIDTH  byte address to memory debug port; word-aligned
- i_debug_data  input  DATA_WIDTH  memory debug word; registered in memory, valid 1 cycle after address
- o_tx_data  output  8  byte to transmitter
- o_tx_valid  output  1  o_tx_data valid
- i_tx_ready  input  1  transmitter accepts byte this cycle
- o_busy  output  1  dump in progress (any state other than IDLE)
- o_done  output  1  one-cycle pulse after last byte accepted

## Operation
- The FSM has five states.
  - IDLE: o_busy=0. On i_start=1, go to ADDR with o_debug_addr=0.
  - ADDR: hold o_debug_addr for one cycle; memory registers the word on the ending edge. Go to LATCH.
  - LATCH: capture i_debug_data into a DATA_WIDTH shift register; clear byte index to 0. Go to SEND.
  - SEND: o_tx_valid=1, o_tx_data = shift register [7:0].
    - On i_tx_ready=1, shift right by 8 and increment byte index.
    - After byte DATA_WIDTH/8−1 is accepted:
      - If o_debug_addr == MEM_SIZE − DATA_WIDTH/8, go to DONE.
      - Otherwise add DATA_WIDTH/8 to o_debug_addr and go to ADDR.
  - DONE: o_done=1 for exactly one cycle, o_debug_addr returns to 0, then IDLE.
- Byte order on the stream: per word, byte at address a, then a+1, a+2, a+3 (LSB first). Words are sent in ascending address order.
- Handshake: a byte transfers only on the cycle with o_tx_valid && i_tx_ready.
  - Once o_tx_valid rises, it stays high and o_tx_data stays stable until accepted.
  - o_tx_valid never depends combinationally on i_tx_ready.
- Address arithmetic is ADDR_WIDTH unsigned. No wrap-around is ever produced: the last address is MEM_SIZE − DATA_WIDTH/8, and the adder never increments past it.
- i_start in any state other than IDLE is ignored; it is neither queued nor a restart.
- i_start coinciding with rst: rst wins.

## Timing
- Reset values: o_debug_addr=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0, state IDLE, shift register 0, byte index 0.
- rst mid-dump: on the next edge all outputs return to reset values. Any unaccepted byte is dropped, and no o_done is emitted.
- i_start sampled at edge E: o_busy=1 from E; ADDR occupies cycle E..E+1.
- Per word with i_tx_ready held high: 2 + DATA_WIDTH/8 cycles (ADDR, LATCH, 4× SEND).
- Full dump at defaults with ready high: 16 words × 6 = 96 cycles, then 1 DONE cycle.
  - First o_tx_valid appears 2 cycles after the start edge.
  - o_done is high in cycle 97 after start; o_busy falls with DONE → IDLE.
- Each cycle of i_tx_ready=0 during SEND adds exactly one cycle; no other state stalls.
- Data memory writes during a dump are permitted. Each word reflects memory contents at its ADDR cycle.

## Structure
- A shared package/include holds:
  - the FSM state encoding localparams (IDLE, ADDR, LATCH, SEND, DONE; 3-bit);
  - the BYTES_PER_WORD = DATA_WIDTH/8 constant, shared with the UART debug unit.
- One natural sub-module: word_serializer.
  - Function: load a DATA_WIDTH word, emit bytes LSB first over valid/ready, assert a last-byte-accepted strobe.
  - Ownership: the top keeps the FSM and the address counter.

## Test plan
- Memory preloaded with byte i = i (0..63), i_tx_ready=1, pulse i_start.
  - Stream is 0x00,0x01,…,0x3F (64 bytes); o_debug_addr steps 0,4,…,60.
  - o_done pulses exactly once, 97 cycles after start.
- Same preload with i_tx_ready toggling 1,0,1,0…
  - Identical byte sequence; o_tx_data stable while valid&&!ready.
  - Duration grows by exactly the number of stalled SEND cycles.
- Word at address 8 = 0xDEADBEEF.
  - Bytes 8..11 of the stream are 0xEF,0xBE,0xAD,0xDE.
- i_start re-pulsed at cycles 10 and 50 of a dump.
  - Exactly 64 bytes and one o_done; no restart.
- rst asserted while in SEND at address 20.
  - Next cycle: o_tx_valid=0, o_busy=0, o_debug_addr=0, no o_done.
  - A new i_start then dumps from address 0.
- MEM_SIZE=16 instance.
  - 16 bytes, last address 12, o_done at cycle 25 with ready high.
